// File: rtl/fir_mac_sequencer.sv
// Sequencer for a time-multiplexed FIR: clears the delay line, accepts samples, steps one shared MAC.
// Optional macro SYMMETRIC_FOLD_EN: symmetric folding, NUM_TAPS/2 steps with a second read address.
module fir_mac_sequencer #(
   parameter  int DATA_W   = 32,
   parameter  int ACC_W    = 32,
   parameter  int NUM_TAPS = 16,
   parameter  int MAC_LAT  = 2,
   localparam int ADDR_W   = $clog2(NUM_TAPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_sample,
   output logic              sample_wr_en,
   output logic [ADDR_W-1:0] sample_wr_addr,
   output logic [DATA_W-1:0] sample_wr_data,
   output logic [ADDR_W-1:0] sample_rd_addr,
   output logic [ADDR_W-1:0] sample_rd_addr_b,
   output logic [ADDR_W-1:0] coeff_addr,
   output logic              mac_clear,
   output logic              mac_en,
   output logic              mac_last,
   input  logic [ACC_W-1:0]  acc_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              busy
);

`ifdef SYMMETRIC_FOLD_EN
   localparam int STEPS = NUM_TAPS / 2;
`else
   localparam int STEPS = NUM_TAPS;
`endif

   localparam int CNT_W = $clog2(NUM_TAPS + MAC_LAT + 1);

   localparam logic [CNT_W-1:0]  INIT_LAST  = CNT_W'(NUM_TAPS - 1);
   localparam logic [CNT_W-1:0]  STEP_LAST  = CNT_W'(STEPS - 1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(MAC_LAT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_TAPS - 1);
   localparam logic [ADDR_W:0]   N_EXT      = (ADDR_W + 1)'(NUM_TAPS);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_MAC,
      ST_DRAIN,
      ST_OUT
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    step_q;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [ADDR_W-1:0]   wr_ptr_d;
   logic [ADDR_W-1:0]   newest_q;
   logic                out_valid_q;
   logic [ACC_W-1:0]    out_data_q;
   logic [ADDR_W-1:0]   step_addr;

   // (a - b) mod NUM_TAPS with an explicit wrap, so non-power-of-two depths work.
   function automatic logic [ADDR_W-1:0] mod_sub(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
      logic [ADDR_W:0] diff;
      if (a >= b) diff = {1'b0, a} - {1'b0, b};
      else        diff = {1'b0, a} + N_EXT - {1'b0, b};
      return diff[ADDR_W-1:0];
   endfunction

   assign step_addr = step_q[ADDR_W-1:0];
   assign wr_ptr_d  = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_INIT;
         step_q      <= '0;
         wr_ptr_q    <= '0;
         newest_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (step_q == INIT_LAST) begin
                  step_q  <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  step_q <= step_q + CNT_W'(1);
               end
            end
            ST_IDLE: begin
               if (in_valid) begin
                  newest_q <= wr_ptr_q;
                  wr_ptr_q <= wr_ptr_d;
                  step_q   <= '0;
                  state_q  <= ST_MAC;
               end
            end
            ST_MAC: begin
               if (step_q == STEP_LAST) begin
                  step_q  <= '0;
                  state_q <= ST_DRAIN;
               end else begin
                  step_q <= step_q + CNT_W'(1);
               end
            end
            ST_DRAIN: begin
               if (step_q == DRAIN_LAST) begin
                  step_q      <= '0;
                  out_data_q  <= acc_in;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_OUT;
               end else begin
                  step_q <= step_q + CNT_W'(1);
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_INIT;
               step_q  <= '0;
            end
         endcase
      end
   end

   // Strobes and addresses decode from registered state; held at zero while reset is asserted.
   always_comb begin
      in_ready         = 1'b0;
      sample_wr_en     = 1'b0;
      sample_wr_addr   = '0;
      sample_wr_data   = '0;
      sample_rd_addr   = '0;
      sample_rd_addr_b = '0;
      coeff_addr       = '0;
      mac_clear        = 1'b0;
      mac_en           = 1'b0;
      mac_last         = 1'b0;
      if (reset) begin
         case (state_q)
            ST_INIT: begin
               sample_wr_en   = 1'b1;
               sample_wr_addr = step_addr;
            end
            ST_IDLE: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  sample_wr_en   = 1'b1;
                  sample_wr_addr = wr_ptr_q;
                  sample_wr_data = in_sample;
               end
            end
            ST_MAC: begin
               mac_en         = 1'b1;
               coeff_addr     = step_addr;
               sample_rd_addr = mod_sub(newest_q, step_addr);
               mac_clear      = (step_q == '0);
               mac_last       = (step_q == STEP_LAST);
`ifdef SYMMETRIC_FOLD_EN
               sample_rd_addr_b = mod_sub(newest_q, LAST_ADDR - step_addr);
`endif
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: vector table for reset/INIT/first sample, then corner sequences.
// Define SYMMETRIC_FOLD_EN for both bench and RTL to exercise the folded build.
module tb_fir_mac_sequencer;

   localparam int NT = 16;
   localparam int ML = 2;
`ifdef SYMMETRIC_FOLD_EN
   localparam int S    = NT / 2;
   localparam bit FOLD = 1'b1;
`else
   localparam int S    = NT;
   localparam bit FOLD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_sample;
   logic        sample_wr_en;
   logic [3:0]  sample_wr_addr;
   logic [31:0] sample_wr_data;
   logic [3:0]  sample_rd_addr;
   logic [3:0]  sample_rd_addr_b;
   logic [3:0]  coeff_addr;
   logic        mac_clear;
   logic        mac_en;
   logic        mac_last;
   logic [31:0] acc_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_samples = 0;

   always #5 clk = ~clk;

   fir_mac_sequencer #(
      .DATA_W(32), .ACC_W(32), .NUM_TAPS(NT), .MAC_LAT(ML)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
      .sample_wr_en(sample_wr_en), .sample_wr_addr(sample_wr_addr), .sample_wr_data(sample_wr_data),
      .sample_rd_addr(sample_rd_addr), .sample_rd_addr_b(sample_rd_addr_b), .coeff_addr(coeff_addr),
      .mac_clear(mac_clear), .mac_en(mac_en), .mac_last(mac_last),
      .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] smp;
      logic        ordy;
      logic [31:0] acc;
      logic        e_ir;
      logic        e_we;
      logic [3:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_me;
      logic [3:0]  e_ca;
      logic [3:0]  e_ra;
      logic [3:0]  e_rb;
      logic        e_mc;
      logic        e_ml;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_busy;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t blank();
      vec_t v;
      v.rst = 1'b1; v.iv = 1'b0; v.smp = '0; v.ordy = 1'b0; v.acc = '0;
      v.e_ir = 1'b0; v.e_we = 1'b0; v.e_wa = '0; v.e_wd = '0;
      v.e_me = 1'b0; v.e_ca = '0; v.e_ra = '0; v.e_rb = '0; v.e_mc = 1'b0; v.e_ml = 1'b0;
      v.e_ov = 1'b0; v.e_od = '0; v.e_busy = 1'b0;
      return v;
   endfunction

   // One sample from the IDLE cycle through accept; leaves the bench in the following IDLE cycle.
   task automatic run_sample(input logic [31:0] smp, input logic [31:0] accv,
                             input logic [3:0] exp_wa, input int hold);
      int lat;
      in_valid  = 1'b1;
      in_sample = smp;
      acc_in    = accv;
      out_ready = 1'b0;
      #1;
      chk("hs_in_ready", in_ready, 1);
      chk("hs_wr_en", sample_wr_en, 1);
      chk("hs_wr_addr", sample_wr_addr, exp_wa);
      chk("hs_wr_data", sample_wr_data, smp);
      next_cycle();
      lat = 1;
      for (int k = 0; k < S; k++) begin
         #1;
         chk($sformatf("mac_en_k%0d", k), mac_en, 1);
         chk($sformatf("coeff_k%0d", k), coeff_addr, k);
         chk($sformatf("rd_a_k%0d", k), sample_rd_addr, (exp_wa + NT - k) % NT);
         chk($sformatf("rd_b_k%0d", k), sample_rd_addr_b, FOLD ? (exp_wa + 1 + k) % NT : 0);
         chk($sformatf("in_ready_mac_k%0d", k), in_ready, 0);
         chk($sformatf("wr_en_mac_k%0d", k), sample_wr_en, 0);
         next_cycle();
         lat++;
      end
      while (out_valid !== 1'b1 && lat < 64) begin
         chk("mac_en_drain", mac_en, 0);
         next_cycle();
         lat++;
      end
      chk("latency", lat, S + ML + 1);
      chk("out_data", out_data, accv);
      for (int h = 0; h < hold; h++) begin
         in_valid  = h[0];
         in_sample = 32'hBAD0_0000 + h;
         acc_in    = 32'h5555_0000 + h;
         #1;
         chk($sformatf("hold_ov_%0d", h), out_valid, 1);
         chk($sformatf("hold_od_%0d", h), out_data, accv);
         chk($sformatf("hold_ir_%0d", h), in_ready, 0);
         chk($sformatf("hold_we_%0d", h), sample_wr_en, 0);
         next_cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("accept_ov", out_valid, 1);
      next_cycle();
      out_ready = 1'b0;
      chk("post_accept_ov", out_valid, 0);
      chk("post_accept_busy", busy, 0);
      chk("post_accept_ir", in_ready, 1);
      n_samples++;
      $display("sample %0d: data=%0h wr_addr=%0d latency=%0d out_data=%0h",
               n_samples, smp, exp_wa, lat, out_data);
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v;
      int   idx;
      reset = 1'b0; in_valid = 1'b0; in_sample = '0; acc_in = '0; out_ready = 1'b0;

      // Build the table: reset, INIT sweep, first sample at wr_ptr 0 through accept.
      for (int i = 0; i < 3; i++) begin
         v = blank(); v.rst = 1'b0; v.e_busy = 1'b1; v.iv = 1'b1; tbl.push_back(v);
      end
      for (int i = 0; i < NT; i++) begin
         v = blank(); v.e_we = 1'b1; v.e_wa = 4'(i); v.e_busy = 1'b1; v.iv = 1'b1; v.smp = 32'h77;
         tbl.push_back(v);
      end
      v = blank(); v.iv = 1'b1; v.smp = 32'd5;
      v.e_ir = 1'b1; v.e_we = 1'b1; v.e_wa = 4'd0; v.e_wd = 32'd5;
      tbl.push_back(v);
      for (int k = 0; k < S; k++) begin
         v = blank(); v.iv = 1'b1; v.smp = 32'd77; v.acc = 32'hDEAD_0000 + k;
         v.e_me = 1'b1; v.e_ca = 4'(k); v.e_ra = 4'((NT - k) % NT);
         v.e_rb = FOLD ? 4'(k + 1) : 4'd0;
         v.e_mc = (k == 0); v.e_ml = (k == S - 1); v.e_busy = 1'b1;
         tbl.push_back(v);
      end
      for (int d = 0; d < ML; d++) begin
         v = blank(); v.e_busy = 1'b1;
         v.acc = (d == ML - 1) ? 32'hCAFE_0005 : 32'h1111_0000 + d;
         tbl.push_back(v);
      end
      v = blank(); v.ordy = 1'b1; v.acc = 32'h0BAD;
      v.e_ov = 1'b1; v.e_od = 32'hCAFE_0005; v.e_busy = 1'b1;
      tbl.push_back(v);
      v = blank(); v.e_ir = 1'b1; v.e_od = 32'hCAFE_0005;
      tbl.push_back(v);

      next_cycle();
      idx = 0;
      foreach (tbl[i]) begin
         reset = tbl[i].rst; in_valid = tbl[i].iv; in_sample = tbl[i].smp;
         out_ready = tbl[i].ordy; acc_in = tbl[i].acc;
         #1;
         chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("v%0d_wr_en", i), sample_wr_en, tbl[i].e_we);
         chk($sformatf("v%0d_wr_addr", i), sample_wr_addr, tbl[i].e_wa);
         chk($sformatf("v%0d_wr_data", i), sample_wr_data, tbl[i].e_wd);
         chk($sformatf("v%0d_mac_en", i), mac_en, tbl[i].e_me);
         chk($sformatf("v%0d_coeff", i), coeff_addr, tbl[i].e_ca);
         chk($sformatf("v%0d_rd_a", i), sample_rd_addr, tbl[i].e_ra);
         chk($sformatf("v%0d_rd_b", i), sample_rd_addr_b, tbl[i].e_rb);
         chk($sformatf("v%0d_clear", i), mac_clear, tbl[i].e_mc);
         chk($sformatf("v%0d_last", i), mac_last, tbl[i].e_ml);
         chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         next_cycle();
         idx++;
      end
      n_samples = 1;
      $display("table: %0d vectors applied, first sample result %0h", idx, out_data);
      in_valid = 1'b0; out_ready = 1'b0; acc_in = '0;

      // Samples 2..17 back-to-back; the 17th wraps to address 0.
      for (int n = 2; n <= 17; n++)
         run_sample(32'(n * 3), 32'h0000_0100 + n, 4'((n - 1) % NT), 0);

      // Output stalled for 10 cycles.
      run_sample(32'h0000_ABCD, 32'h1234_5678, 4'd1, 10);

      // Reset asserted during MAC step 7 of a sample at address 2.
      in_valid = 1'b1; in_sample = 32'h99; acc_in = 32'h0;
      #1;
      chk("t5_wr_addr", sample_wr_addr, 2);
      next_cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 7; k++) next_cycle();
      #1;
      chk("t5_step7_rd", sample_rd_addr, 4'd11);
      chk("t5_step7_mac_en", mac_en, 1);
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      #1;
      chk("t5_mac_en_after", mac_en, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_init_we", sample_wr_en, 1);
      chk("t5_init_wa0", sample_wr_addr, 0);
      chk("t5_in_ready", in_ready, 0);
      next_cycle();
      for (int i = 1; i < NT; i++) begin
         #1;
         chk($sformatf("t5_init_wa%0d", i), sample_wr_addr, i);
         chk($sformatf("t5_init_wd%0d", i), sample_wr_data, 0);
         next_cycle();
      end
      $display("reset mid-MAC: INIT rerun complete");
      run_sample(32'h0000_0042, 32'hFEED_0001, 4'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
